// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the serial ripple-carry adder family.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit configuration still needs a 1-bit counter to keep port widths legal.
  function automatic int calc_cnt_w(input int width, input int digit);
    int n;
    n = width / digit;
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/carry_digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder built from full_add cells,
// structured like the full_sub / ripple-borrow subtractor.
module full_add (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module carry_digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out
);
  logic [DIGIT:0] c_s;

  assign c_s[0] = c_in;
  assign c_out  = c_s[DIGIT];

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    full_add u_fa (
      .a  (a_d[i]),
      .b  (b_d[i]),
      .ci (c_s[i]),
      .s  (s_d[i]),
      .co (c_s[i+1])
    );
  end
endmodule

// File: rtl/serial_ripple_adder.sv
// Multi-cycle adder: adds DIGIT bits per clock, carrying between digits in a
// flip-flop, with valid/ready handshakes on both sides.
module serial_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int CW   = calc_cnt_w(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_e           state_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] res_nxt_s;
  logic [DIGIT-1:0] dsum_s;
  logic             dcarry_s;

  carry_digit_adder #(.DIGIT(DIGIT)) u_cda (
    .a_d   (a_sh_r[DIGIT-1:0]),
    .b_d   (b_sh_r[DIGIT-1:0]),
    .c_in  (carry_r),
    .s_d   (dsum_s),
    .c_out (dcarry_s)
  );

  // Digit sums enter at the top, so after NDIG steps digit 0 sits at the LSB.
  if (DIGIT == WIDTH) begin : g_single
    assign res_nxt_s = dsum_s;
  end else begin : g_multi
    assign res_nxt_s = {dsum_s, res_r[WIDTH-1:DIGIT]};
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      res_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r     <= a;
            b_sh_r     <= b;
            carry_r    <= cin;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          res_r   <= res_nxt_s;
          carry_r <= dcarry_s;
          a_sh_r  <= a_sh_r >> DIGIT;
          b_sh_r  <= b_sh_r >> DIGIT;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = res_r;
  assign cout      = carry_r;

endmodule

// File: tb/tb_serial_ripple_adder.sv
// Scoreboard bench for serial_ripple_adder at DIGIT = 1, 4 and 16 (WIDTH = 16).
module tb_serial_ripple_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        iv  [3];
  logic        ir  [3];
  logic [15:0] ta  [3];
  logic [15:0] tb  [3];
  logic        tc  [3];
  logic        ov  [3];
  logic        ordy[3];
  logic [15:0] ts  [3];
  logic        tco [3];

  exp_t sb[$];
  int   n_assert;
  int   n_fail;

  serial_ripple_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(ta[0]), .b(tb[0]),
    .cin(tc[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(ts[0]), .cout(tco[0]));
  serial_ripple_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(ta[1]), .b(tb[1]),
    .cin(tc[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(ts[1]), .cout(tco[1]));
  serial_ripple_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(ta[2]), .b(tb[2]),
    .cin(tc[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(ts[2]), .cout(tco[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic ci);
    logic [16:0] t;
    t = {1'b0, av} + {1'b0, bv} + {16'd0, ci};
    return '{s: t[15:0], c: t[16]};
  endfunction

  // Offer one operand set, wait for the accept edge, then wait for out_valid.
  task automatic drive_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, output int lat, output bit ok);
    bit rdy;
    int guard;
    ok = 1'b1;
    lat = 0;
    guard = 0;
    iv[k] = 1'b1; ta[k] = av; tb[k] = bv; tc[k] = ci;
    do begin
      rdy = ir[k];
      @(posedge clk); #1;
      guard++;
    end while (!rdy && guard < 200);
    iv[k] = 1'b0; ta[k] = 16'($urandom); tb[k] = 16'($urandom); tc[k] = 1'($urandom);
    if (!rdy) ok = 1'b0;
    while (!ov[k] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ov[k]) ok = 1'b0;
  endtask

  task automatic consume(input int k);
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      n_assert += 4;
      if (ir[k] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, ir[k]); end
      if (ov[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, ov[k]); end
      if (ts[k] !== 16'h0000) begin n_fail++; $display("FAIL reset_sum[%0d]: got %h expected 0000", k, ts[k]); end
      if (tco[k] !== 1'b0) begin n_fail++; $display("FAIL reset_cout[%0d]: got %b expected 0", k, tco[k]); end
    end
  endtask

  task automatic check_op(input string name, input int k, input logic [15:0] av,
                          input logic [15:0] bv, input logic ci, input int ndig);
    int   lat;
    bit   ok;
    exp_t e;
    sb.push_back(model(av, bv, ci));
    drive_op(k, av, bv, ci, lat, ok);
    e = sb.pop_front();
    n_assert += 4;
    if (!ok) begin n_fail++; $display("FAIL %s_timeout: got no result expected out_valid", name); end
    if (lat != ndig) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, ndig); end
    if (ts[k] !== e.s) begin n_fail++; $display("FAIL %s_sum: got %h expected %h (a=%h b=%h cin=%b)", name, ts[k], e.s, av, bv, ci); end
    if (tco[k] !== e.c) begin n_fail++; $display("FAIL %s_cout: got %b expected %b", name, tco[k], e.c); end
    consume(k);
  endtask

  task automatic test_basic();
    check_op("basic", 1, 16'h1234, 16'h4321, 1'b0, 4);
    n_assert += 2;
    if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL basic_release_valid: got %b expected 0", ov[1]); end
    if (ir[1] !== 1'b1) begin n_fail++; $display("FAIL basic_release_ready: got %b expected 1", ir[1]); end
  endtask

  task automatic test_carry();
    check_op("carry_ripple", 1, 16'hFFFF, 16'h0001, 1'b0, 4);
    check_op("carry_all", 1, 16'hFFFF, 16'hFFFF, 1'b1, 4);
  endtask

  task automatic test_backpressure();
    int   lat;
    bit   ok;
    exp_t e;
    sb.push_back(model(16'hC000, 16'h5000, 1'b1));
    drive_op(1, 16'hC000, 16'h5000, 1'b1, lat, ok);
    e = sb.pop_front();
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL bp_timeout: got no result expected out_valid"); end
    for (int c = 0; c < 6; c++) begin
      iv[1] = (c % 2 == 0) ? 1'b1 : 1'b0;
      ta[1] = 16'($urandom); tb[1] = 16'($urandom); tc[1] = 1'($urandom);
      @(posedge clk); #1;
      n_assert += 4;
      if (ov[1] !== 1'b1) begin n_fail++; $display("FAIL bp_valid c%0d: got %b expected 1", c, ov[1]); end
      if (ir[1] !== 1'b0) begin n_fail++; $display("FAIL bp_ready c%0d: got %b expected 0", c, ir[1]); end
      if (ts[1] !== e.s) begin n_fail++; $display("FAIL bp_sum c%0d: got %h expected %h", c, ts[1], e.s); end
      if (tco[1] !== e.c) begin n_fail++; $display("FAIL bp_cout c%0d: got %b expected %b", c, tco[1], e.c); end
    end
    iv[1] = 1'b0;
    consume(1);
    repeat (6) begin
      @(posedge clk); #1;
      n_assert += 2;
      if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_valid: got %b expected 0", ov[1]); end
      if (ir[1] !== 1'b1) begin n_fail++; $display("FAIL bp_ignored_ready: got %b expected 1", ir[1]); end
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    int   n_acc;
    int   n_out;
    int   acc_cyc[2];
    bit   rdy;
    bit   ivb;
    exp_t e;
    cyc = 0; n_acc = 0; n_out = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    sb.push_back(model(16'h0F0F, 16'h00F1, 1'b0));
    sb.push_back(model(16'h8000, 16'h8000, 1'b0));
    iv[1] = 1'b1; ordy[1] = 1'b1;
    ta[1] = 16'h0F0F; tb[1] = 16'h00F1; tc[1] = 1'b0;
    while (n_out < 2 && cyc < 40) begin
      rdy = ir[1];
      ivb = iv[1];
      @(posedge clk); #1;
      cyc++;
      if (rdy && ivb) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin
          ta[1] = 16'h8000; tb[1] = 16'h8000; tc[1] = 1'b0;
        end else begin
          iv[1] = 1'b0; ta[1] = 16'($urandom); tb[1] = 16'($urandom);
        end
      end
      if (ov[1] === 1'b1) begin
        e = sb.pop_front();
        n_out++;
        n_assert += 2;
        if (ts[1] !== e.s) begin n_fail++; $display("FAIL b2b_sum%0d: got %h expected %h", n_out, ts[1], e.s); end
        if (tco[1] !== e.c) begin n_fail++; $display("FAIL b2b_cout%0d: got %b expected %b", n_out, tco[1], e.c); end
      end
    end
    iv[1] = 1'b0; ordy[1] = 1'b0;
    n_assert += 2;
    if (n_out != 2) begin n_fail++; $display("FAIL b2b_results: got %0d expected 2", n_out); end
    if (acc_cyc[1] - acc_cyc[0] != 6) begin
      n_fail++; $display("FAIL b2b_interval: got %0d expected 6", acc_cyc[1] - acc_cyc[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    bit rdy;
    int guard;
    guard = 0;
    iv[1] = 1'b1; ta[1] = 16'hAAAA; tb[1] = 16'h5555; tc[1] = 1'b1;
    do begin
      rdy = ir[1];
      @(posedge clk); #1;
      guard++;
    end while (!rdy && guard < 50);
    iv[1] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_assert += 4;
    if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", ov[1]); end
    if (ir[1] !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", ir[1]); end
    if (ts[1] !== 16'h0000) begin n_fail++; $display("FAIL midrst_sum: got %h expected 0000", ts[1]); end
    if (tco[1] !== 1'b0) begin n_fail++; $display("FAIL midrst_cout: got %b expected 0", tco[1]); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      n_assert++;
      if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL midrst_no_result: got %b expected 0", ov[1]); end
    end
    check_op("after_rst", 1, 16'h0001, 16'h0001, 1'b0, 4);
  endtask

  task automatic test_random_sweep();
    int ndig;
    for (int k = 0; k < 3; k++) begin
      ndig = (k == 0) ? 16 : ((k == 1) ? 4 : 1);
      for (int i = 0; i < 1000; i++) begin
        check_op($sformatf("rand_k%0d_%0d", k, i), k, 16'($urandom), 16'($urandom), 1'($urandom), ndig);
      end
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; ta[k] = 16'h0000; tb[k] = 16'h0000; tc[k] = 1'b0;
    end
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_carry();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random_sweep();
    n_assert++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
